// File: rtl/adsr_envelope.sv
// ADSR envelope generator: gate-driven five-state machine stepping a 32-bit
// Q2.30 amplitude accumulator once per sample tick; output is the Q2.14 top half.
module adsr_envelope (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        gate,
    input  logic [31:0] attack_step,
    input  logic [31:0] decay_step,
    input  logic [15:0] sustain_level,
    input  logic [31:0] release_step,
    output logic [15:0] envelope,
    output logic [2:0]  env_state,
    output logic        active,
    output logic        done
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ATTACK  = 3'd1;
    localparam logic [2:0] ST_DECAY   = 3'd2;
    localparam logic [2:0] ST_SUSTAIN = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;

    localparam logic [32:0] AMP_MAX = 33'h0_4000_0000;

    logic [2:0]  state, next_state;
    logic [31:0] amp_reg, next_amp;
    logic        gate_d;
    logic        done_reg, next_done;

    logic        rise, fall;
    logic [15:0] sus_level;
    logic [31:0] sus_amp;
    logic [32:0] attack_sum;
    logic [32:0] decay_diff;

    assign rise = gate & ~gate_d;
    assign fall = ~gate & gate_d;

    assign sus_level  = (sustain_level > 16'h4000) ? 16'h4000 : sustain_level;
    assign sus_amp    = {sus_level, 16'h0000};
    assign attack_sum = {1'b0, amp_reg} + {1'b0, attack_step};
    // Signed 33-bit difference so a decay step larger than the amplitude cannot wrap past SUS
    assign decay_diff = {1'b0, amp_reg} - {1'b0, decay_step};

    always_comb begin
        next_state = state;
        next_amp   = amp_reg;
        next_done  = 1'b0;
        if (rise) begin
            next_state = ST_ATTACK;
        end else if (fall && (state == ST_ATTACK || state == ST_DECAY || state == ST_SUSTAIN)) begin
            next_state = ST_RELEASE;
        end else if (tick) begin
            case (state)
                ST_IDLE: begin
                    next_amp = 32'h0;
                end
                ST_ATTACK: begin
                    if (attack_step == 32'h0 || attack_sum >= AMP_MAX) begin
                        next_amp   = AMP_MAX[31:0];
                        next_state = ST_DECAY;
                    end else begin
                        next_amp = attack_sum[31:0];
                    end
                end
                ST_DECAY: begin
                    if (decay_step == 32'h0 || $signed(decay_diff) <= $signed({1'b0, sus_amp})) begin
                        next_amp   = sus_amp;
                        next_state = ST_SUSTAIN;
                    end else begin
                        next_amp = decay_diff[31:0];
                    end
                end
                ST_SUSTAIN: begin
                    next_amp = sus_amp;
                end
                ST_RELEASE: begin
                    if (release_step == 32'h0 || release_step >= amp_reg) begin
                        next_amp   = 32'h0;
                        next_state = ST_IDLE;
                        next_done  = 1'b1;
                    end else begin
                        next_amp = amp_reg - release_step;
                    end
                end
                default: begin
                    next_amp   = 32'h0;
                    next_state = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            amp_reg  <= 32'h0;
            gate_d   <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            state    <= next_state;
            amp_reg  <= next_amp;
            gate_d   <= gate;
            done_reg <= next_done;
        end
    end

    assign envelope  = amp_reg[31:16];
    assign env_state = state;
    assign active    = (state != ST_IDLE);
    assign done      = done_reg;

endmodule

// File: tb/tb_adsr_envelope.sv
// Self-checking bench for adsr_envelope: table-driven ADSR cycle plus hand-written
// corner sequences, with expectations queued at drive time and popped after each clk.
module tb_adsr_envelope;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ATT  = 3'd1;
    localparam logic [2:0] S_DEC  = 3'd2;
    localparam logic [2:0] S_SUS  = 3'd3;
    localparam logic [2:0] S_REL  = 3'd4;

    logic        clk;
    logic        reset;
    logic        tick;
    logic        gate;
    logic [31:0] attack_step;
    logic [31:0] decay_step;
    logic [15:0] sustain_level;
    logic [31:0] release_step;
    logic [15:0] envelope;
    logic [2:0]  env_state;
    logic        active;
    logic        done;

    typedef struct {
        logic        tick;
        logic        gate;
        logic [15:0] env;
        logic [2:0]  st;
        logic        done;
    } vec_t;

    typedef struct {
        logic [15:0] env;
        logic [2:0]  st;
        logic        done;
    } exp_t;

    vec_t vecs[$];
    exp_t scoreboard[$];
    int   assert_count = 0;
    int   fail_count   = 0;

    adsr_envelope dut (
        .clk           (clk),
        .reset         (reset),
        .tick          (tick),
        .gate          (gate),
        .attack_step   (attack_step),
        .decay_step    (decay_step),
        .sustain_level (sustain_level),
        .release_step  (release_step),
        .envelope      (envelope),
        .env_state     (env_state),
        .active        (active),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic void addVec(logic t, logic g, logic [15:0] e, logic [2:0] s, logic d);
        vec_t v;
        v.tick = t; v.gate = g; v.env = e; v.st = s; v.done = d;
        vecs.push_back(v);
    endfunction

    function automatic void pushExp(logic [15:0] e, logic [2:0] s, logic d);
        exp_t x;
        x.env = e; x.st = s; x.done = d;
        scoreboard.push_back(x);
    endfunction

    task automatic checkOutput(input string name);
        exp_t x;
        assert_count++;
        if (scoreboard.size() == 0) begin
            fail_count++;
            $display("[TB] FAIL %s scoreboard empty actual=none required=entry", name);
            return;
        end
        x = scoreboard.pop_front();
        if (envelope !== x.env) begin
            fail_count++;
            $display("[TB] FAIL %s envelope actual=%h required=%h", name, envelope, x.env);
        end
        assert_count++;
        if (env_state !== x.st) begin
            fail_count++;
            $display("[TB] FAIL %s env_state actual=%0d required=%0d", name, env_state, x.st);
        end
        assert_count++;
        if (done !== x.done) begin
            fail_count++;
            $display("[TB] FAIL %s done actual=%b required=%b", name, done, x.done);
        end
        assert_count++;
        if (active !== (x.st != S_IDLE)) begin
            fail_count++;
            $display("[TB] FAIL %s active actual=%b required=%b", name, active, (x.st != S_IDLE));
        end
    endtask

    task automatic applyStimulus(input logic t, input logic g, input logic [15:0] e,
                                 input logic [2:0] s, input logic d, input string name);
        @(negedge clk);
        tick = t;
        gate = g;
        pushExp(e, s, d);
        @(posedge clk);
        #1;
        checkOutput(name);
    endtask

    // Release from start_env (multiple of 0x0400) with release_step 0x0400_0000 and tick every clk
    task automatic releaseToZero(input logic [15:0] start_env, input string name);
        logic [15:0] e;
        e = start_env;
        while (e > 16'h0400) begin
            e = e - 16'h0400;
            applyStimulus(1'b1, 1'b0, e, S_REL, 1'b0, name);
        end
        applyStimulus(1'b1, 1'b0, 16'h0000, S_IDLE, 1'b1, name);
        applyStimulus(1'b1, 1'b0, 16'h0000, S_IDLE, 1'b0, name);
    endtask

    task automatic setSteps(input logic [31:0] a, input logic [31:0] dc,
                            input logic [15:0] s, input logic [31:0] r);
        attack_step = a; decay_step = dc; sustain_level = s; release_step = r;
    endtask

    initial begin
        reset = 1'b1;
        tick  = 1'b0;
        gate  = 1'b0;
        setSteps(32'h1000_0000, 32'h0800_0000, 16'h2000, 32'h0400_0000);

        // Basic ADSR cycle, gate high for 20 clk
        addVec(1, 0, 16'h0000, S_IDLE, 0);
        addVec(1, 1, 16'h0000, S_ATT, 0);
        addVec(1, 1, 16'h1000, S_ATT, 0);
        addVec(1, 1, 16'h2000, S_ATT, 0);
        addVec(1, 1, 16'h3000, S_ATT, 0);
        addVec(1, 1, 16'h4000, S_DEC, 0);
        addVec(1, 1, 16'h3800, S_DEC, 0);
        addVec(1, 1, 16'h3000, S_DEC, 0);
        addVec(1, 1, 16'h2800, S_DEC, 0);
        addVec(1, 1, 16'h2000, S_SUS, 0);
        for (int i = 0; i < 11; i++) addVec(1, 1, 16'h2000, S_SUS, 0);
        addVec(1, 0, 16'h2000, S_REL, 0);
        for (int i = 1; i < 8; i++) addVec(1, 0, 16'(16'h2000 - 16'h0400 * i), S_REL, 0);
        addVec(1, 0, 16'h0000, S_IDLE, 1);
        addVec(1, 0, 16'h0000, S_IDLE, 0);

        repeat (2) @(posedge clk);
        #1;
        pushExp(16'h0000, S_IDLE, 1'b0);
        checkOutput("reset_state");
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++)
            applyStimulus(vecs[i].tick, vecs[i].gate, vecs[i].env, vecs[i].st, vecs[i].done,
                          $sformatf("basic_%0d", i));

        // Early release after two attack ticks
        applyStimulus(1, 1, 16'h0000, S_ATT, 0, "early_rise");
        applyStimulus(1, 1, 16'h1000, S_ATT, 0, "early_att1");
        applyStimulus(1, 1, 16'h2000, S_ATT, 0, "early_att2");
        applyStimulus(1, 0, 16'h2000, S_REL, 0, "early_fall");
        releaseToZero(16'h2000, "early_rel");

        // Retrigger from release at 0x1000, rise coincident with tick
        applyStimulus(1, 1, 16'h0000, S_ATT, 0, "retrig_rise");
        applyStimulus(1, 1, 16'h1000, S_ATT, 0, "retrig_att1");
        applyStimulus(1, 1, 16'h2000, S_ATT, 0, "retrig_att2");
        applyStimulus(1, 0, 16'h2000, S_REL, 0, "retrig_fall");
        applyStimulus(1, 0, 16'h1C00, S_REL, 0, "retrig_rel1");
        applyStimulus(1, 0, 16'h1800, S_REL, 0, "retrig_rel2");
        applyStimulus(1, 0, 16'h1400, S_REL, 0, "retrig_rel3");
        applyStimulus(1, 0, 16'h1000, S_REL, 0, "retrig_rel4");
        applyStimulus(1, 1, 16'h1000, S_ATT, 0, "retrig_prio");
        applyStimulus(1, 1, 16'h2000, S_ATT, 0, "retrig_resume");
        applyStimulus(1, 0, 16'h2000, S_REL, 0, "retrig_fall2");
        releaseToZero(16'h2000, "retrig_rel");

        // Zero steps with over-range sustain clamped to 0x4000
        setSteps(32'h0, 32'h0, 16'h5000, 32'h0);
        applyStimulus(1, 1, 16'h0000, S_ATT, 0, "zero_rise");
        applyStimulus(1, 1, 16'h4000, S_DEC, 0, "zero_att");
        applyStimulus(1, 1, 16'h4000, S_SUS, 0, "zero_dec");
        applyStimulus(1, 1, 16'h4000, S_SUS, 0, "zero_sus1");
        applyStimulus(1, 1, 16'h4000, S_SUS, 0, "zero_sus2");
        applyStimulus(1, 0, 16'h4000, S_REL, 0, "zero_fall");
        applyStimulus(1, 0, 16'h0000, S_IDLE, 1, "zero_rel");
        applyStimulus(1, 0, 16'h0000, S_IDLE, 0, "zero_idle");

        // Tick every 4th clk: envelope moves only on tick cycles
        setSteps(32'h1000_0000, 32'h0800_0000, 16'h2000, 32'h0400_0000);
        applyStimulus(0, 1, 16'h0000, S_ATT, 0, "tick_rise");
        for (int k = 1; k <= 2; k++) begin
            for (int j = 0; j < 3; j++)
                applyStimulus(0, 1, 16'(16'h1000 * (k - 1)), S_ATT, 0, "tick_hold");
            applyStimulus(1, 1, 16'(16'h1000 * k), S_ATT, 0, "tick_step");
        end
        applyStimulus(0, 0, 16'h2000, S_REL, 0, "tick_fall");
        releaseToZero(16'h2000, "tick_rel");

        // Reset mid-decay with gate held high across reset release
        applyStimulus(1, 1, 16'h0000, S_ATT, 0, "rst_rise");
        for (int k = 1; k <= 3; k++)
            applyStimulus(1, 1, 16'(16'h1000 * k), S_ATT, 0, "rst_att");
        applyStimulus(1, 1, 16'h4000, S_DEC, 0, "rst_dec_in");
        applyStimulus(1, 1, 16'h3800, S_DEC, 0, "rst_dec1");
        @(negedge clk);
        reset = 1'b1;
        #1;
        pushExp(16'h0000, S_IDLE, 1'b0);
        checkOutput("rst_async");
        @(posedge clk);
        #1;
        pushExp(16'h0000, S_IDLE, 1'b0);
        checkOutput("rst_held");
        #1;
        reset = 1'b0;
        applyStimulus(1, 1, 16'h0000, S_ATT, 0, "rst_gate_rise");
        applyStimulus(1, 1, 16'h1000, S_ATT, 0, "rst_att1");

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
